// File: rtl/mul_seq_pkg.sv
// mul_seq shared definitions.
// Widths and FSM state encoding.
package mul_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq request/result handshake bundle.
// master = requester/consumer, slave = multiplier.
interface mul_seq_if;
  import mul_seq_pkg::*;

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] product;
  logic             busy;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, product, busy
  );

endinterface

// File: rtl/mul_seq_add32.sv
// 32-bit ripple-carry adder, carry out dropped.
// Built from bitwise operators only.
module add32
  import mul_seq_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s
);

  logic cy;

  // Ripple the carry bit by bit
  always_comb begin
    cy = 1'b0;
    s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier.
// One iteration per cycle, low 32 bits kept.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mul_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum;
  logic             last;

  add32 u_add (
    .x (acc_q),
    .y (mcand_q),
    .s (sum)
  );

  // Final iteration: 32nd one, or multiplier exhausted
  always_comb begin
    last = (cnt_q == '1) ||
           (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));
  end

  // FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          prod_d  = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE) && !rst;
  assign bus.res_valid   = (state_q == DONE);
  assign bus.product     = prod_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq.
// Two instances: early exit on and off.
module tb_mul_seq;

  typedef struct {
    logic [31:0] prod;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  bit   rr_rand = 1'b0;
  logic rr1 = 1'b1;
  logic rr0 = 1'b1;

  exp_t q1[$];
  exp_t q0[$];
  exp_t cur1, cur0;
  bit   seen1 = 1'b0;
  bit   seen0 = 1'b0;
  int   acc1 = 0;
  int   acc0 = 0;

  mul_seq_if if1 ();
  mul_seq_if if0 ();

  mul_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  mul_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endfunction

  function automatic int ref_lat(
    input bit          early,
    input logic [31:0] bv
  );
    if (!early) return 32;
    for (int i = 31; i >= 0; i--)
      if (bv[i]) return i + 1;
    return 1;
  endfunction

  always begin
    @(posedge clk);
    #2;
    if1.res_ready = rr_rand ?
      ($urandom_range(0, 2) != 0) : rr1;
    if0.res_ready = rr_rand ?
      ($urandom_range(0, 2) != 0) : rr0;
  end

  always @(negedge clk) begin
    if (rst) seen1 = 1'b0;
    else begin
      if (if1.start_valid && if1.start_ready)
        acc1 = cyc + 1;
      if (if1.res_valid) begin
        if (!seen1) begin
          seen1 = 1'b1;
          chk("res1_expected", 64'(q1.size() != 0), 1);
          if (q1.size() != 0) begin
            cur1 = q1.pop_front();
            chk("res1_product", if1.product, cur1.prod);
            chk("res1_latency", cyc - acc1, cur1.lat);
          end
        end else chk("res1_hold", if1.product, cur1.prod);
        if (if1.res_ready) seen1 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) seen0 = 1'b0;
    else begin
      if (if0.start_valid && if0.start_ready)
        acc0 = cyc + 1;
      if (if0.res_valid) begin
        if (!seen0) begin
          seen0 = 1'b1;
          chk("res0_expected", 64'(q0.size() != 0), 1);
          if (q0.size() != 0) begin
            cur0 = q0.pop_front();
            chk("res0_product", if0.product, cur0.prod);
            chk("res0_latency", cyc - acc0, cur0.lat);
          end
        end else chk("res0_hold", if0.product, cur0.prod);
        if (if0.res_ready) seen0 = 1'b0;
      end
    end
  end

  task automatic issue(
    input bit          e1,
    input logic [31:0] av,
    input logic [31:0] bv
  );
    exp_t  e;
    logic  rdy;
    int    t;
    string nm;
    e.prod = av * bv;
    e.lat  = ref_lat(e1, bv);
    nm     = e1 ? "accept1" : "accept0";
    if (e1) begin
      if1.a = av;
      if1.b = bv;
      if1.start_valid = 1'b1;
    end else begin
      if0.a = av;
      if0.b = bv;
      if0.start_valid = 1'b1;
    end
    t   = 0;
    rdy = 1'b0;
    while (!rdy && t < 300) begin
      @(negedge clk);
      rdy = e1 ? if1.start_ready : if0.start_ready;
      t++;
    end
    chk(nm, rdy, 1);
    if (rdy) begin
      if (e1) q1.push_back(e);
      else q0.push_back(e);
      @(posedge clk);
    end
    #1;
    if (e1) begin
      if1.start_valid = 1'b0;
      if1.a = $urandom;
      if1.b = $urandom;
    end else begin
      if0.start_valid = 1'b0;
      if0.a = $urandom;
      if0.b = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    if1.start_valid = 1'b0;
    if0.start_valid = 1'b0;
    if1.a = '0;
    if1.b = '0;
    if0.a = '0;
    if0.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sready1", if1.start_ready, 0);
    chk("rst_sready0", if0.start_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_sready1", if1.start_ready, 1);
    chk("init_sready0", if0.start_ready, 1);
    chk("init_valid", if1.res_valid, 0);
    chk("init_product", if1.product, 0);
    chk("init_busy", if1.busy, 0);
    @(posedge clk);
    #1;

    issue(1'b1, 32'd3, 32'd5);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b1, 32'h1234, 32'h0);
    repeat (4) @(posedge clk);
    #1 rr1 = 1'b0;

    issue(1'b1, 32'd7, 32'd6);
    if1.start_valid = 1'b1;
    t = 0;
    while (!if1.res_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_reach_done", if1.res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_product", if1.product, 42);
      chk("bp_valid", if1.res_valid, 1);
      chk("bp_sready", if1.start_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rr1 = 1'b1;
    @(posedge clk);
    #1;
    rr1 = 1'b0;
    if1.start_valid = 1'b0;
    @(negedge clk);
    chk("bp_sready_after", if1.start_ready, 1);
    chk("bp_valid_after", if1.res_valid, 0);
    chk("bp_keep_product", if1.product, 42);
    @(posedge clk);
    #1 rr1 = 1'b1;

    issue(1'b1, 32'd100, 32'h0000_FFFF);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", if1.busy, 1);
    chk("mid_sready", if1.start_ready, 0);
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", if1.res_valid, 0);
    chk("rst_product", if1.product, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_sready", if1.start_ready, 1);
    @(posedge clk);
    #1;
    issue(1'b1, 32'd7, 32'd6);

    issue(1'b0, 32'd2, 32'd1);

    rr_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++)
          issue(1'b1, $urandom,
                $urandom >> $urandom_range(0, 32));
      end
      begin
        for (int j = 0; j < 10; j++)
          issue(1'b0, $urandom,
                $urandom >> $urandom_range(0, 32));
      end
    join
    @(posedge clk);
    #1 rr_rand = 1'b0;
    rr1 = 1'b1;
    rr0 = 1'b1;
    t = 0;
    while ((q1.size() != 0 || q0.size() != 0 ||
            if1.busy || if0.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_idle1", if1.busy, 0);
    chk("drain_idle0", if0.busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
